// File: rtl/nim_game_engine.sv
// Nim game core: heap registers, two-player turn FSM, winner detection
// and per-column RGB data for the 8x8 LED matrix scanner.
module nim_game_engine #(
    parameter int                    NUM_ROWS   = 4,
    parameter logic [4*NUM_ROWS-1:0] INIT_HEAPS = 16'h1357,
    parameter bit                    MISERE     = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_game,
    input  logic [NUM_ROWS-1:0]     row_pulse,
    input  logic                    end_turn,
    input  logic [2:0]              col_num,
    output logic [7:0]              red_vect,
    output logic [7:0]              green_vect,
    output logic [7:0]              blue_vect,
    output logic [4*NUM_ROWS-1:0]   heap_cnt,
    output logic                    cur_player,
    output logic                    game_over,
    output logic                    winner,
    output logic                    err
);

    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [1:0] {
        FIRST,
        TAKING,
        OVER
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    heap_q [NUM_ROWS];
    logic [3:0]    heap_d [NUM_ROWS];
    logic [3:0]    init_h [NUM_ROWS];
    logic [RW-1:0] lock_q, lock_d;
    logic          player_q, player_d;
    logic          winner_q, winner_d;
    logic          err_q, err_d;

    logic [RW-1:0] row_idx;
    logic [3:0]    sel_cnt;
    logic          one_hot;
    logic          multi;
    logic          all_zero;
    logic          do_dec;

    // Heap 0 lives in the most significant nibble of INIT_HEAPS.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            init_h[r] = INIT_HEAPS[4*(NUM_ROWS-1-r) +: 4];
        end
    end

    always_comb begin
        row_idx  = '0;
        sel_cnt  = '0;
        all_zero = 1'b1;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_pulse[r]) begin
                row_idx = RW'(r);
                sel_cnt = heap_q[r];
            end
            if (heap_q[r] != 4'd0) begin
                all_zero = 1'b0;
            end
        end
        one_hot = ($countones(row_pulse) == 1);
        multi   = ($countones(row_pulse) > 1);
    end

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        player_d = player_q;
        winner_d = winner_q;
        err_d    = 1'b0;
        do_dec   = 1'b0;
        heap_d   = heap_q;

        if (new_game) begin
            state_d  = FIRST;
            lock_d   = '0;
            player_d = 1'b0;
            winner_d = 1'b0;
            heap_d   = init_h;
        end else begin
            unique case (state_q)
                FIRST: begin
                    if (multi) begin
                        err_d = 1'b1;
                    end else if (one_hot) begin
                        if (sel_cnt == 4'd0) begin
                            err_d = 1'b1;
                        end else begin
                            do_dec  = 1'b1;
                            lock_d  = row_idx;
                            state_d = TAKING;
                        end
                    end
                end
                TAKING: begin
                    if (multi) begin
                        err_d = 1'b1;
                    end else if (one_hot) begin
                        if (row_idx != lock_q || sel_cnt == 4'd0) begin
                            err_d = 1'b1;
                        end else begin
                            do_dec = 1'b1;
                        end
                    end else if (end_turn) begin
                        if (all_zero) begin
                            state_d  = OVER;
                            winner_d = player_q ^ MISERE;
                        end else begin
                            player_d = ~player_q;
                            state_d  = FIRST;
                        end
                    end
                end
                OVER: begin
                end
                default: begin
                    state_d = FIRST;
                end
            endcase

            for (int r = 0; r < NUM_ROWS; r++) begin
                if (do_dec && row_idx == RW'(r)) begin
                    heap_d[r] = heap_q[r] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FIRST;
            heap_q   <= init_h;
            lock_q   <= '0;
            player_q <= 1'b0;
            winner_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            heap_q   <= heap_d;
            lock_q   <= lock_d;
            player_q <= player_d;
            winner_q <= winner_d;
            err_q    <= err_d;
        end
    end

    assign cur_player = player_q;
    assign game_over  = (state_q == OVER);
    assign winner     = winner_q;
    assign err        = err_q;

    always_comb begin
        heap_cnt = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            heap_cnt[4*(NUM_ROWS-1-r) +: 4] = heap_q[r];
        end
    end

    logic       col_ok;
    logic       col_lock;
    logic [3:0] col_cnt;
    logic [7:0] pattern;

    // Columns 2h and 2h+1 both show heap h as a bottom-up bar.
    always_comb begin
        col_ok   = 1'b0;
        col_lock = 1'b0;
        col_cnt  = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (col_num[2:1] == 2'(r)) begin
                col_ok   = 1'b1;
                col_cnt  = heap_q[r];
                col_lock = (lock_q == RW'(r));
            end
        end
        for (int i = 0; i < 8; i++) begin
            pattern[i] = (4'(i) < col_cnt);
        end
    end

    always_comb begin
        red_vect   = '0;
        green_vect = '0;
        blue_vect  = '0;
        if (state_q == OVER) begin
            if (winner_q) begin
                blue_vect = 8'hFF;
            end else begin
                red_vect = 8'hFF;
            end
        end else if (col_ok) begin
            if (player_q) begin
                blue_vect = pattern;
            end else begin
                red_vect = pattern;
            end
            if (state_q == TAKING && col_lock) begin
                green_vect = pattern;
            end
        end
    end

endmodule

// File: tb/tb_nim_game_engine.sv
// Self-checking bench for nim_game_engine: model + scoreboard queue,
// display scans, and a misere instance driven in parallel.
module tb_nim_game_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] row_pulse = '0;
    logic       end_turn = 1'b0;
    logic [2:0] col_num = '0;

    logic [7:0]  red_vect, green_vect, blue_vect;
    logic [15:0] heap_cnt;
    logic        cur_player, game_over, winner, err;

    logic [7:0]  m_red, m_green, m_blue;
    logic [15:0] m_heap_cnt;
    logic        m_cur_player, m_game_over, m_winner, m_err_o;

    always #5 clk = ~clk;

    nim_game_engine dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .row_pulse  (row_pulse),
        .end_turn   (end_turn),
        .col_num    (col_num),
        .red_vect   (red_vect),
        .green_vect (green_vect),
        .blue_vect  (blue_vect),
        .heap_cnt   (heap_cnt),
        .cur_player (cur_player),
        .game_over  (game_over),
        .winner     (winner),
        .err        (err)
    );

    nim_game_engine #(.MISERE(1'b1)) dut_misere (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .row_pulse  (row_pulse),
        .end_turn   (end_turn),
        .col_num    (col_num),
        .red_vect   (m_red),
        .green_vect (m_green),
        .blue_vect  (m_blue),
        .heap_cnt   (m_heap_cnt),
        .cur_player (m_cur_player),
        .game_over  (m_game_over),
        .winner     (m_winner),
        .err        (m_err_o)
    );

    typedef struct {
        logic [15:0] hc;
        logic        p;
        logic        ov;
        logic        w;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [3:0] m_h [4];
    logic       m_p, m_win, m_err;
    int         m_st, m_lock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] rp, input logic et,
                         input logic ng, input logic rs);
        int n;
        int r;
        bit empty;
        n = $countones(rp);
        r = 0;
        for (int i = 0; i < 4; i++) if (rp[i]) r = i;
        m_err = 1'b0;
        if (rs || ng) begin
            m_h[0] = 4'd1; m_h[1] = 4'd3; m_h[2] = 4'd5; m_h[3] = 4'd7;
            m_p = 1'b0; m_st = 0; m_lock = 0; m_win = 1'b0;
        end else if (m_st == 2) begin
        end else if (n > 1) begin
            m_err = 1'b1;
        end else if (n == 1) begin
            if (m_st == 0) begin
                if (m_h[r] == 0) m_err = 1'b1;
                else begin
                    m_h[r] = m_h[r] - 4'd1;
                    m_lock = r;
                    m_st = 1;
                end
            end else begin
                if (r != m_lock || m_h[r] == 0) m_err = 1'b1;
                else m_h[r] = m_h[r] - 4'd1;
            end
        end else if (et && m_st == 1) begin
            empty = 1;
            for (int i = 0; i < 4; i++) if (m_h[i] != 0) empty = 0;
            if (empty) begin
                m_st = 2;
                m_win = m_p;
            end else begin
                m_p = ~m_p;
                m_st = 0;
            end
        end
    endtask

    task automatic step(input logic [3:0] rp, input logic et,
                        input logic ng = 1'b0, input logic rs = 1'b0);
        exp_t e;
        @(negedge clk);
        row_pulse = rp;
        end_turn  = et;
        new_game  = ng;
        reset     = rs;
        model(rp, et, ng, rs);
        e.hc = {m_h[0], m_h[1], m_h[2], m_h[3]};
        e.p  = m_p;
        e.ov = (m_st == 2);
        e.w  = m_win;
        e.e  = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        row_pulse = '0;
        end_turn  = 1'b0;
        new_game  = 1'b0;
        reset     = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("heap_cnt", 32'(heap_cnt), 32'(e.hc));
            check("cur_player", 32'(cur_player), 32'(e.p));
            check("game_over", 32'(game_over), 32'(e.ov));
            check("err", 32'(err), 32'(e.e));
            if (e.ov) check("winner", 32'(winner), 32'(e.w));
        end
    endtask

    task automatic scan();
        logic [7:0] pat, er, eg, eb;
        int h;
        for (int c = 0; c < 8; c++) begin
            h = c / 2;
            pat = '0;
            for (int i = 0; i < 8; i++) pat[i] = (i < int'(m_h[h]));
            er = '0; eg = '0; eb = '0;
            if (m_st == 2) begin
                if (m_win) eb = 8'hFF;
                else er = 8'hFF;
            end else begin
                if (m_p) eb = pat;
                else er = pat;
                if (m_st == 1 && m_lock == h) eg = pat;
            end
            col_num = 3'(c);
            #1;
            check($sformatf("red_c%0d", c), 32'(red_vect), 32'(er));
            check($sformatf("green_c%0d", c), 32'(green_vect), 32'(eg));
            check($sformatf("blue_c%0d", c), 32'(blue_vect), 32'(eb));
        end
    endtask

    task automatic take_all(input int r, input int n);
        for (int k = 0; k < n; k++) step(4'(1 << r), 1'b0);
        step(4'b0000, 1'b1);
    endtask

    initial begin
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        check("rst_heaps", 32'(heap_cnt), 32'h1357);
        col_num = 3'd6;
        #1;
        check("rst_col6_red", 32'(red_vect), 32'h7F);
        scan();

        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        col_num = 3'd4;
        #1;
        check("green_c4", 32'(green_vect), 32'h07);
        scan();
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0100, 1'b1);
        check("same_cyc_heap2", 32'(heap_cnt[7:4]), 32'd2);
        step(4'b0000, 1'b1);
        check("turn_b", 32'(cur_player), 32'd1);
        scan();

        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        check("ng_heaps", 32'(heap_cnt), 32'h1357);
        scan();

        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0, 1'b1);

        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        take_all(1, 3);
        take_all(2, 5);
        for (int k = 0; k < 7; k++) step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b1);
        check("over", 32'(game_over), 32'd1);
        check("winner_b", 32'(winner), 32'd1);
        check("misere_over", 32'(m_game_over), 32'd1);
        check("misere_winner", 32'(m_winner), 32'd0);
        scan();

        step(4'b0011, 1'b0);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        check("rst_over", 32'(game_over), 32'd0);
        scan();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
